// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS transfer out, valid/ready response back.
// Optional ACCESS timeout abort is built only when APB_MST_TIMEOUT_EN is defined.
module apb_master_bridge #(
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;
  state_t state, state_nxt;

  logic              timeout_hit;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;

`ifdef APB_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ABORT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts ACCESS cycles that saw PREADY low; the abort fires on the last allowed one.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                                           wait_cnt <= '0;
    else if (state == S_SETUP)                              wait_cnt <= '0;
    else if (state == S_ACCESS && !PREADY && wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == S_ACCESS) && !PREADY && (wait_cnt == CNT_ABORT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (PREADY || timeout_hit) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; anything not touched holds.
  always_comb begin
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    case (state)
      S_IDLE: if (cmd_valid) begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = cmd_write;
        paddr_d   = cmd_addr;
        pwdata_d  = cmd_wdata;
      end
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        // A same-cycle PREADY wins over the timeout abort.
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      busy        <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table, reset/timeout sequences, random transfers.
module tb_apb_master_bridge;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [2:0] PADDR;
  logic [7:0] PWDATA, PRDATA;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prdata;
    logic       slverr;
    int         hold;
    logic       poke;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One transfer from IDLE; the expected timeline is: SETUP at N+1, ACCESS for waits+1
  // cycles, response from N+3+waits, held for 'hold' cycles before being consumed.
  task automatic do_xfer(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                         input int waits, input logic [7:0] rd, input logic err,
                         input int hold, input logic poke,
                         input logic [7:0] exp_rd, input logic exp_err);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    PREADY = 1'b0; PRDATA = ~rd; PSLVERR = ~err;
    tick();
    cmd_valid = poke; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~wd;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_busy", busy, 1);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_paddr", PADDR, a);
    tick();
    for (int k = 0; k <= waits; k++) begin
      chk("acc_psel", PSEL, 1);
      chk("acc_penable", PENABLE, 1);
      chk("acc_paddr", PADDR, a);
      chk("acc_pwrite", PWRITE, wr);
      chk("acc_pwdata", PWDATA, wd);
      chk("acc_rsp_valid", rsp_valid, 0);
      PREADY  = (k == waits);
      PRDATA  = (k == waits) ? rd : ~rd;
      PSLVERR = (k == waits) ? err : ~err;
      tick();
    end
    PREADY = 1'b0; PRDATA = 8'h00; PSLVERR = 1'b0;
    rsp_ready = 1'b0;
    chk("resp_psel", PSEL, 0);
    chk("resp_penable", PENABLE, 0);
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) rsp_ready = 1'b1;
      chk("resp_valid", rsp_valid, 1);
      chk("resp_rdata", rsp_rdata, exp_rd);
      chk("resp_err", rsp_err, exp_err);
      chk("resp_timeout", rsp_timeout, 0);
      chk("resp_cmd_ready", cmd_ready, 0);
      tick();
      if (h != hold) chk("resp_no_new_psel", PSEL, 0);
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_psel", PSEL, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 3'b000, 8'h5C, 0, 8'hFF, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 3'b101, 8'h00, 2, 8'hA7, 1'b0, 1, 1'b0, 8'hA7, 1'b0};
    vecs[2] = '{1'b1, 3'b010, 8'h33, 0, 8'h99, 1'b1, 0, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 3'b111, 8'h11, 1, 8'h3C, 1'b0, 4, 1'b1, 8'h3C, 1'b0};
    vecs[4] = '{1'b0, 3'b001, 8'h00, 0, 8'h81, 1'b1, 0, 1'b0, 8'h81, 1'b1};
    vecs[5] = '{1'b1, 3'b110, 8'hE4, 3, 8'h5A, 1'b0, 2, 1'b1, 8'h00, 1'b0};

    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    PREADY = 0; PRDATA = 0; PSLVERR = 0;
    #2 PRESETn = 1'b0;
    tick(); tick();
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    PRESETn = 1'b1;
    tick();

    foreach (vecs[i])
      do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].prdata,
              vecs[i].slverr, vecs[i].hold, vecs[i].poke, vecs[i].exp_rdata, vecs[i].exp_err);

    // Asynchronous reset in the middle of ACCESS drops the transfer.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd4; PREADY = 0;
    tick();
    cmd_valid = 0;
    tick();
    chk("pre_rst_penable", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_rst_psel", PSEL, 0);
    chk("async_rst_penable", PENABLE, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_busy", busy, 0);
    tick();
    PRESETn = 1'b1;
    PREADY = 1'b1; PRDATA = 8'h77;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    tick(); tick();
    chk("post_rst_no_rsp", rsp_valid, 0);
    chk("post_rst_no_psel", PSEL, 0);
    PREADY = 1'b0;

`ifdef APB_MST_TIMEOUT_EN
    // PREADY never arrives: abort after 16 ACCESS cycles.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd4; PRDATA = 8'hC3;
    tick();
    cmd_valid = 0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      chk("to_acc_psel", PSEL, 1);
      chk("to_acc_rsp_valid", rsp_valid, 0);
      tick();
    end
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", PSEL, 0);
    chk("to_penable", PENABLE, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("to_done_cmd_ready", cmd_ready, 1);
    // PREADY on the 16th ACCESS cycle completes normally.
    do_xfer(1'b0, 3'd3, 8'h00, 15, 8'h5A, 1'b0, 0, 1'b0, 8'h5A, 1'b0);
`else
    // Without the timeout the bridge waits as long as the slave needs.
    do_xfer(1'b0, 3'd3, 8'h00, 20, 8'h5A, 1'b0, 0, 1'b0, 8'h5A, 1'b0);
`endif

    // Random transfers against the expected transaction outcome.
    for (int t = 0; t < 40; t++) begin
      logic       wr, er, pk;
      logic [2:0] a;
      logic [7:0] wd, rd;
      int         w, h;
      wr = 1'($urandom); er = 1'($urandom_range(0, 3) == 0); pk = 1'($urandom);
      a = 3'($urandom); wd = 8'($urandom); rd = 8'($urandom);
      w = $urandom_range(0, 5); h = $urandom_range(0, 3);
      do_xfer(wr, a, wd, w, rd, er, h, pk, wr ? 8'h00 : rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB requester that converts a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response port.
- Drives the APB side of the SPI register block (PADDR 3 bits, 8-bit data) from a local controller or test sequencer.
- One transfer in flight at a time. Waits for PREADY, so slaves that insert wait states are supported.

Parameters:
- ADDR_W, 3, width of PADDR and cmd_addr.
- DATA_W, 8, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before abort. Used only with APB_MST_TIMEOUT_EN.

Ports:
- PCLK  in  1  APB clock
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  captured PRDATA (0 for writes)
- rsp_err  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  high in any state except IDLE
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PREADY  in  1  slave ready
- PRDATA  in  DATA_W  slave read data
- PSLVERR  in  1  slave error

Behaviour:
- Reset (async, PRESETn low), regardless of state:
  - State returns to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy and the wait counter all go to 0.
  - A transfer in progress is dropped with no response.
- All APB outputs and response outputs are registered.
- cmd_ready = (state == IDLE). It is combinational from state only.
- FSM states:
  - IDLE: cmd_valid accepted when cmd_ready is high. Latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA. Set PSEL=1, PENABLE=0. Go to SETUP.
  - SETUP (exactly one cycle): set PENABLE=1 and clear the wait counter. Go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=0: stay in ACCESS and increment the wait counter.
    - PREADY=1: set rsp_rdata to PRDATA if PWRITE=0, else 0. Set rsp_err = PSLVERR and rsp_timeout=0. Drop PSEL and PENABLE to 0, set rsp_valid=1, go to RESP.
  - RESP: rsp_valid stays high and rsp_rdata/rsp_err/rsp_timeout stay stable until rsp_ready=1. On rsp_ready=1, clear rsp_valid and go to IDLE.
- No new command is accepted in the cycle the response is consumed. Minimum spacing between transfers is therefore 4 cycles.
- Latency: command accepted at edge N. PSEL is high from N+1. PENABLE is high from N+2. With PREADY=1 at the first ACCESS cycle, rsp_valid is high from N+3. Each PREADY=0 cycle adds one cycle.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. They hold their last values in IDLE and RESP.
- PSLVERR and PRDATA are sampled only in the ACCESS cycle where PREADY=1.
- cmd_valid while busy has no effect. The command is not latched and cmd_ready=0.
- rsp_ready while rsp_valid=0 is ignored.
- Wait counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates at TIMEOUT_CYCLES.

Optional Feature:
- Macro: APB_MST_TIMEOUT_EN.
- Defined: in ACCESS, if PREADY=0 and the wait counter == TIMEOUT_CYCLES-1, abort.
  - Drop PSEL and PENABLE.
  - Set rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Go to RESP.
  - PREADY=1 in the same cycle as the abort condition takes priority: normal completion.
- Undefined: the counter and abort logic are not built, the bridge waits for PREADY indefinitely, and rsp_timeout is tied to 0.

Test Plan:
- Write, no wait states: cmd addr=3'b000, wdata=8'h5C, PREADY=1 in first ACCESS cycle.
  - PSEL high from N+1, PENABLE high from N+2, PWDATA=8'h5C.
  - rsp_valid from N+3 with rsp_err=0 and rsp_rdata=0.
- Read with 2 wait states: addr=3'b101, PRDATA=8'hA7, PREADY low for 2 ACCESS cycles.
  - ACCESS lasts 3 cycles and PADDR stays stable.
  - rsp_rdata=8'hA7 at N+5.
- Slave error: PSLVERR=1 together with PREADY=1 on a write.
  - rsp_err=1 and rsp_timeout=0.
  - PSEL=0 in the next cycle.
- Response backpressure: rsp_ready low for 4 cycles, and cmd_valid driven during that time.
  - rsp_valid and rsp_rdata hold.
  - cmd_ready=0 and no new PSEL.
  - After rsp_ready, cmd_ready=1 one cycle later.
- Reset mid-ACCESS: PRESETn low while PENABLE=1.
  - PSEL, PENABLE and rsp_valid go to 0 immediately, without waiting for PCLK.
  - After release, cmd_ready=1 and no response is produced.
- With APB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0: after 16 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_timeout=1, and PSEL drops.
